// File: rtl/sb_mac16_acc.sv
// sb_mac16_acc -- 16x16 (or dual 8x8) multiplier feeding a chained pair of
// 16-bit adders and a 32-bit accumulator.
//
// Ports
//   CLK   : sole clock, rising edge
//   RSTN  : asynchronous active-low reset (clears accumulator and all registers)
//   CE    : clock enable for every register
//   A, B  : 16-bit multiplier operands
//   C, D  : 16-bit top / bottom adder operands
//   O     : 32-bit result, O[31:16] top half, O[15:0] bottom half
//
// Optional feature: define SB_MAC16_INPUT_REGS_EN to make A_REG/B_REG/C_REG/D_REG
// insert input registers. Without it the inputs feed the logic directly and
// those parameters are ignored.
module sb_mac16_acc #(
    parameter int C_REG                    = 0,
    parameter int A_REG                    = 0,
    parameter int B_REG                    = 0,
    parameter int D_REG                    = 0,
    parameter int TOP_8x8_MULT_REG         = 0,
    parameter int BOT_8x8_MULT_REG         = 0,
    parameter int PIPELINE_16x16_MULT_REG1 = 0,
    parameter int PIPELINE_16x16_MULT_REG2 = 0,
    parameter int MODE_8x8                 = 0,
    parameter int A_SIGNED                 = 0,
    parameter int B_SIGNED                 = 0,
    parameter int TOPADDSUB_UPPERINPUT     = 0,
    parameter int BOTADDSUB_UPPERINPUT     = 0,
    parameter int TOPADDSUB_LOWERINPUT     = 0,
    parameter int BOTADDSUB_LOWERINPUT     = 0,
    parameter int TOPADDSUB_CARRYSELECT    = 0,
    parameter int BOTADDSUB_CARRYSELECT    = 0,
    parameter int TOPOUTPUT_SELECT         = 0,
    parameter int BOTOUTPUT_SELECT         = 0
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        CE,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [15:0] C,
    input  logic [15:0] D,
    output logic [31:0] O
);

    logic [15:0] a_in, b_in, c_in, d_in;

`ifdef SB_MAC16_INPUT_REGS_EN
    logic [15:0] a_q, b_q, c_q, d_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            d_q <= '0;
        end else if (CE) begin
            a_q <= A;
            b_q <= B;
            c_q <= C;
            d_q <= D;
        end
    end

    assign a_in = (A_REG != 0) ? a_q : A;
    assign b_in = (B_REG != 0) ? b_q : B;
    assign c_in = (C_REG != 0) ? c_q : C;
    assign d_in = (D_REG != 0) ? d_q : D;
`else
    assign a_in = A;
    assign b_in = B;
    assign c_in = C;
    assign d_in = D;
`endif

    // Multipliers. Operands are sign/zero-extended to the product width so a
    // plain unsigned multiply truncated to that width gives the right bits
    // for any mix of signedness.
    logic        a_sx, b_sx, a_hi_sx, b_hi_sx;
    logic [31:0] p16_raw;
    logic [15:0] p_top_raw, p_bot_raw;

    assign a_sx    = (A_SIGNED != 0) && a_in[15];
    assign b_sx    = (B_SIGNED != 0) && b_in[15];
    assign a_hi_sx = a_sx;
    assign b_hi_sx = b_sx;

    assign p16_raw   = {{16{a_sx}}, a_in} * {{16{b_sx}}, b_in};
    assign p_top_raw = {{8{a_hi_sx}}, a_in[15:8]} * {{8{b_hi_sx}}, b_in[15:8]};
    // Bottom 8x8 is always unsigned: its operands are the low bytes.
    assign p_bot_raw = {8'h00, a_in[7:0]} * {8'h00, b_in[7:0]};

    // Optional product pipeline stages; unused registers are pruned.
    logic [15:0] p_top_q, p_bot_q, p_top, p_bot;
    logic [31:0] p16_q1, p16_q2, p16_s1, p16_s2, p;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            p_top_q <= '0;
            p_bot_q <= '0;
            p16_q1  <= '0;
            p16_q2  <= '0;
        end else if (CE) begin
            p_top_q <= p_top_raw;
            p_bot_q <= p_bot_raw;
            p16_q1  <= p16_raw;
            p16_q2  <= p16_s1;
        end
    end

    assign p_top  = (TOP_8x8_MULT_REG != 0) ? p_top_q : p_top_raw;
    assign p_bot  = (BOT_8x8_MULT_REG != 0) ? p_bot_q : p_bot_raw;
    assign p16_s1 = (PIPELINE_16x16_MULT_REG1 != 0) ? p16_q1 : p16_raw;
    assign p16_s2 = (PIPELINE_16x16_MULT_REG2 != 0) ? p16_q2 : p16_s1;
    assign p      = (MODE_8x8 != 0) ? {p_top, p_bot} : p16_s2;

    // Adders: bottom first, its carry/sign can feed the top for a 32-bit add.
    logic [31:0] q;
    logic [15:0] bot_up, bot_lo, top_up, top_lo, top_sum;
    logic [16:0] bot_sum;
    logic        bot_ci, top_ci;

    assign bot_up = (BOTADDSUB_UPPERINPUT != 0) ? d_in : q[15:0];
    assign top_up = (TOPADDSUB_UPPERINPUT != 0) ? c_in : q[31:16];

    always_comb begin
        bot_lo = {16{b_in[15]}};
        case (BOTADDSUB_LOWERINPUT)
            0:       bot_lo = b_in;
            1:       bot_lo = p_bot;
            2:       bot_lo = p[15:0];
            default: bot_lo = {16{b_in[15]}};
        endcase
    end

    assign bot_ci  = (BOTADDSUB_CARRYSELECT == 1);
    assign bot_sum = {1'b0, bot_up} + {1'b0, bot_lo} + {16'h0000, bot_ci};

    always_comb begin
        top_lo = {16{bot_sum[15]}};
        case (TOPADDSUB_LOWERINPUT)
            0:       top_lo = a_in;
            1:       top_lo = p_top;
            2:       top_lo = p[31:16];
            default: top_lo = {16{bot_sum[15]}};
        endcase
    end

    always_comb begin
        top_ci = 1'b0;
        case (TOPADDSUB_CARRYSELECT)
            1:       top_ci = 1'b1;
            3:       top_ci = bot_sum[16];
            default: top_ci = 1'b0;
        endcase
    end

    assign top_sum = top_up + top_lo + {15'h0000, top_ci};

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)   q <= '0;
        else if (CE) q <= {top_sum, bot_sum[15:0]};
    end

    always_comb begin
        O[31:16] = top_sum;
        case (TOPOUTPUT_SELECT)
            0:       O[31:16] = top_sum;
            1:       O[31:16] = q[31:16];
            2:       O[31:16] = p_top;
            default: O[31:16] = p[31:16];
        endcase
        O[15:0] = bot_sum[15:0];
        case (BOTOUTPUT_SELECT)
            0:       O[15:0] = bot_sum[15:0];
            1:       O[15:0] = q[15:0];
            2:       O[15:0] = p_bot;
            default: O[15:0] = p[15:0];
        endcase
    end

endmodule

// File: tb/tb_sb_mac16_acc.sv
// Bench for sb_mac16_acc: three configurations driven from shared inputs.
//   u_acc : 32-bit accumulate {C,D} + A*B (B signed), registered output
//   u_8x8 : dual 8x8 products on the output (A signed)
//   u_cmb : combinational top C+A+1, bottom D+{16{B[15]}}+1
module tb_sb_mac16_acc;

    logic        clk, rstn, ce;
    logic [15:0] a, b, c, d;
    logic [31:0] o_acc, o_8x8, o_cmb;

    int n_tests = 0;
    int n_fail  = 0;

    sb_mac16_acc #(
        .B_SIGNED(1),
        .TOPADDSUB_UPPERINPUT(1), .TOPADDSUB_LOWERINPUT(2), .TOPADDSUB_CARRYSELECT(3),
        .BOTADDSUB_UPPERINPUT(1), .BOTADDSUB_LOWERINPUT(2), .BOTADDSUB_CARRYSELECT(0),
        .TOPOUTPUT_SELECT(1), .BOTOUTPUT_SELECT(1)
    ) u_acc (.CLK(clk), .RSTN(rstn), .CE(ce), .A(a), .B(b), .C(c), .D(d), .O(o_acc));

    sb_mac16_acc #(
        .MODE_8x8(1), .A_SIGNED(1),
        .TOPOUTPUT_SELECT(3), .BOTOUTPUT_SELECT(3)
    ) u_8x8 (.CLK(clk), .RSTN(rstn), .CE(ce), .A(a), .B(b), .C(c), .D(d), .O(o_8x8));

    sb_mac16_acc #(
        .TOPADDSUB_UPPERINPUT(1), .TOPADDSUB_LOWERINPUT(0), .TOPADDSUB_CARRYSELECT(1),
        .BOTADDSUB_UPPERINPUT(1), .BOTADDSUB_LOWERINPUT(3), .BOTADDSUB_CARRYSELECT(1),
        .TOPOUTPUT_SELECT(0), .BOTOUTPUT_SELECT(0)
    ) u_cmb (.CLK(clk), .RSTN(rstn), .CE(ce), .A(a), .B(b), .C(c), .D(d), .O(o_cmb));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_acc_next(input logic [15:0] fa, fb, fc, fd);
        longint pa, pb, r;
        pa = fa;
        pb = fb;
        if (fb[15]) pb = pb - 65536;
        r = {16'h0, fc, fd} + pa * pb;
        return r[31:0];
    endfunction

    function automatic logic [31:0] m_8x8(input logic [15:0] fa, fb);
        longint ta, tb, lo, hi;
        ta = fa[15:8];
        if (fa[15]) ta = ta - 256;
        tb = fb[15:8];
        hi = ta * tb;
        lo = fa[7:0] * fb[7:0];
        return {hi[15:0], lo[15:0]};
    endfunction

    function automatic logic [31:0] m_cmb(input logic [15:0] fa, fb, fc, fd);
        int hi, lo;
        hi = (fc + fa + 1) % 65536;
        lo = (fd + (fb[15] ? 65535 : 0) + 1) % 65536;
        return {hi[15:0], lo[15:0]};
    endfunction

    logic [31:0] mq;
    always @(posedge clk or negedge rstn) begin
        if (!rstn)   mq <= '0;
        else if (ce) mq <= m_acc_next(a, b, c, d);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rstn) begin
            chk("model_acc", o_acc, mq);
            chk("model_8x8", o_8x8, m_8x8(a, b));
            chk("model_cmb", o_cmb, m_cmb(a, b, c, d));
        end
    end

    task automatic edge1;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [15:0] na, nb, nc, nd);
        a = na; b = nb; c = nc; d = nd;
    endtask

    task automatic rst_pulse;
        rstn = 1'b0;
        #1;
        chk("rst_pulse_o", o_acc, 32'h0);
        rstn = 1'b1;
    endtask

    logic [15:0] vec_a [6] = '{16'h1234, 16'hFFFF, 16'h8001, 16'h0000, 16'h7FFF, 16'hA5A5};
    logic [15:0] vec_b [6] = '{16'h0010, 16'hFFFF, 16'h0003, 16'h8000, 16'h7FFF, 16'h5A5A};
    logic [15:0] vec_c [6] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h0000, 16'h1111, 16'hFFFE};
    logic [15:0] vec_d [6] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h1234, 16'h2222, 16'h0003};
    logic        vec_ce[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        logic [31:0] acc;
        rstn = 1'b0;
        ce   = 1'b1;
        drive(16'h0, 16'h0, 16'h0, 16'h0);
        #3;
        chk("reset_o", o_acc, 32'h0);

        // 3 * -2 accumulated onto zero
        #4;
        rstn = 1'b1;
        drive(16'h0003, 16'hFFFE, 16'h0000, 16'h0000);
        edge1();
        chk("mul_signed_neg", o_acc, 32'hFFFF_FFFA);

        // unsigned A with MSB set times signed -1
        rst_pulse();
        drive(16'h8000, 16'hFFFF, 16'h0000, 16'h0000);
        edge1();
        chk("mul_a_msb", o_acc, 32'hFFFF_8000);

        // accumulate 5*4 three times from zero, feeding the previous result back
        rst_pulse();
        acc = 32'h0;
        for (int k = 1; k <= 3; k++) begin
            drive(16'd5, 16'd4, acc[31:16], acc[15:0]);
            edge1();
            acc = 32'd20 * k;
            chk("accum_step", o_acc, acc);
        end

        // carry from bottom into top adder
        drive(16'd1, 16'd1, 16'h0000, 16'hFFFF);
        edge1();
        chk("carry_chain", o_acc, 32'h0001_0000);

        // CE low: accumulator holds while inputs move
        ce = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            edge1();
            chk("ce_hold", o_acc, 32'h0001_0000);
        end

        // asynchronous reset mid-cycle
        #1;
        rstn = 1'b0;
        #1;
        chk("async_reset", o_acc, 32'h0);
        edge1();
        chk("reset_hold", o_acc, 32'h0);
        rstn = 1'b1;
        ce   = 1'b1;

        // dual 8x8 and combinational adder literals
        drive(16'h0203, 16'h0405, 16'h1234, 16'h00FF);
        #1;
        chk("dual8x8", o_8x8, 32'h0008_000F);
        drive(16'hFF03, 16'h0205, 16'h0000, 16'h0000);
        #1;
        chk("dual8x8_signed_top", o_8x8, 32'hFFFE_000F);
        drive(16'h02FF, 16'h02FF, 16'h0000, 16'h0000);
        #1;
        chk("dual8x8_bot_unsigned", o_8x8, 32'h0004_FE01);
        drive(16'h0001, 16'h8000, 16'h1234, 16'h00FF);
        #1;
        chk("cmb_b15_set", o_cmb, 32'h1236_00FF);
        drive(16'h0001, 16'h0001, 16'h1234, 16'h00FF);
        #1;
        chk("cmb_b15_clr", o_cmb, 32'h1236_0100);
        drive(16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF);
        #1;
        chk("cmb_wrap", o_cmb, 32'hFFFF_0000);

        // directed table, checked by the model each cycle
        for (int i = 0; i < 6; i++) begin
            drive(vec_a[i], vec_b[i], vec_c[i], vec_d[i]);
            ce = vec_ce[i];
            edge1();
        end
        edge1();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
